// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: operand/amount widths and the rotator state
// type, common to the sequential right rotator and a future left rotator.
package alu_pkg;

  localparam int ALU_W     = 4;
  localparam int ALU_AMT_W = 2;

  typedef enum logic {
    ROT_IDLE   = 1'b0,
    ROT_ROTATE = 1'b1
  } rot_state_t;

endpackage

// File: rtl/rr_4bit_seq_rotr1.sv
// rotr1: combinational single-position right rotate; the LSB wraps into the MSB.
module rotr1 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = {din[0], din[WIDTH-1:1]};

endmodule

// File: rtl/rr_4bit_seq.sv
// rr_4bit_seq: sequential right rotator, one bit position per clock, with a
// start/busy/done handshake. Define RR_4BIT_SEQ_CARRY_EN to add the cout output.
module rr_4bit_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int AMT_W = ALU_AMT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R
`ifdef RR_4BIT_SEQ_CARRY_EN
  ,
  output logic             cout
`endif
);

  rot_state_t       state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt, shreg_rot;
  logic [AMT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] r_nxt;
  logic             done_nxt;

  // Only the low amount bits select a rotation; the rest are don't-care.
  logic unused_amt_hi;
  assign unused_amt_hi = ^B[WIDTH-1:AMT_W];

`ifdef RR_4BIT_SEQ_CARRY_EN
  logic carry, carry_nxt, cout_nxt;
`endif

  rotr1 #(.WIDTH(WIDTH)) u_rotr1 (
    .din  (shreg),
    .dout (shreg_rot)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ROT_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ROT_IDLE:   if (start) state_nxt = ROT_ROTATE;
      ROT_ROTATE: if (cnt == '0) state_nxt = ROT_IDLE;
      default:    state_nxt = ROT_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    busy      = (state == ROT_ROTATE);
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    r_nxt     = R;
    done_nxt  = 1'b0;
`ifdef RR_4BIT_SEQ_CARRY_EN
    carry_nxt = carry;
    cout_nxt  = cout;
`endif
    case (state)
      ROT_IDLE: begin
        if (start) begin
          shreg_nxt = A;
          cnt_nxt   = B[AMT_W-1:0];
`ifdef RR_4BIT_SEQ_CARRY_EN
          carry_nxt = 1'b0;
`endif
        end
      end
      ROT_ROTATE: begin
        if (cnt != '0) begin
          shreg_nxt = shreg_rot;
          cnt_nxt   = cnt - 1'b1;
`ifdef RR_4BIT_SEQ_CARRY_EN
          carry_nxt = shreg[0];
`endif
        end else begin
          r_nxt    = shreg;
          done_nxt = 1'b1;
`ifdef RR_4BIT_SEQ_CARRY_EN
          cout_nxt = carry;
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath and result registers; R and cout hold between completions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
      R     <= '0;
      done  <= 1'b0;
`ifdef RR_4BIT_SEQ_CARRY_EN
      carry <= 1'b0;
      cout  <= 1'b0;
`endif
    end else begin
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
      R     <= r_nxt;
      done  <= done_nxt;
`ifdef RR_4BIT_SEQ_CARRY_EN
      carry <= carry_nxt;
      cout  <= cout_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_rr_4bit_seq.sv
// Scoreboard bench for rr_4bit_seq: the driver predicts each accepted operation
// from rotate arithmetic; a negedge monitor compares on every done pulse.
module tb_rr_4bit_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic       busy, done;
  logic [3:0] R;
`ifdef RR_4BIT_SEQ_CARRY_EN
  logic       cout;
`endif

  rr_4bit_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .R     (R)
`ifdef RR_4BIT_SEQ_CARRY_EN
    ,
    .cout  (cout)
`endif
  );

  always #5 clk = ~clk;

  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  typedef struct {
    logic [3:0] r;
    logic       c;
    int         de;
  } exp_t;

  exp_t       q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         free_edge = 0;
  int         acc_edge = 1;
  int         done_edge = 0;
  logic [3:0] exp_r = '0;
  logic       exp_c = 1'b0;

  function automatic logic [3:0] rotr(input logic [3:0] a, input int n);
    logic [7:0] t;
    t = {a, a} >> n;
    return t[3:0];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, ecount);
    end
  endtask

  // Drive one cycle of inputs; predict the result if the block is idle at the next edge.
  task automatic cycle(input logic s, input logic [3:0] a, input logic [3:0] b);
    int   n, k;
    exp_t e;
    start = s;
    A     = a;
    B     = b;
    if (s && rst_n && (ecount + 1 >= free_edge)) begin
      n    = int'(b[1:0]);
      k    = ecount + 1;
      e.r  = rotr(a, n);
      e.c  = (n > 0) ? a[n-1] : 1'b0;
      e.de = k + n + 1;
      q.push_back(e);
      acc_edge  = k;
      done_edge = e.de;
      free_edge = e.de + 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'($urandom), 4'($urandom));
  endtask

  task automatic wait_free();
    int guard = 0;
    while (ecount + 1 < free_edge && guard < 10) begin
      idle(1);
      guard++;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 32'(busy), 32'(ecount >= acc_edge && ecount < done_edge));
      if (done) begin
        if (q.size() == 0) begin
          check("spurious_done", 32'(done), 32'(0));
        end else begin
          exp_t e;
          e = q.pop_front();
          check("done_edge", 32'(ecount), 32'(e.de));
          exp_r = e.r;
          exp_c = e.c;
        end
      end
      check("R", 32'(R), 32'(exp_r));
`ifdef RR_4BIT_SEQ_CARRY_EN
      check("cout", 32'(cout), 32'(exp_c));
`endif
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_R", 32'(R), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    rst_n = 1'b1;
    idle(2);

    cycle(1'b1, 4'b0110, 4'b0000); idle(3);
    cycle(1'b1, 4'b1011, 4'b0001); idle(3);
    cycle(1'b1, 4'b1011, 4'b0010); idle(4);
    cycle(1'b1, 4'b1000, 4'b0011); idle(5);
    cycle(1'b1, 4'b1011, 4'b1101);
    cycle(1'b1, 4'b1111, 4'b0000);
    cycle(1'b1, 4'b1111, 4'b0011);
    idle(3);
    cycle(1'b1, 4'b1011, 4'b0001);
    wait_free();
    cycle(1'b1, 4'b0011, 4'b0001);
    wait_free();
    cycle(1'b1, 4'b1001, 4'b0010);
    wait_free();
    cycle(1'b1, 4'b1011, 4'b0010);
    wait_free();
    cycle(1'b1, 4'b1101, 4'b0000);
    idle(3);

    // Reset in the middle of a 3-step rotation
    cycle(1'b1, 4'b1011, 4'b0011);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_R", 32'(R), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    q.delete();
    free_edge = 0;
    acc_edge  = 1;
    done_edge = 0;
    exp_r     = '0;
    exp_c     = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 2) != 0), 4'($urandom), 4'($urandom));
    end

    begin
      int guard = 0;
      while (q.size() != 0 && guard < 20) begin
        idle(1);
        guard++;
      end
      check("drain_pending", 32'(q.size()), 32'(0));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
